// File: rtl/mult_arbiter_if.sv
// Request/acknowledge bundle between two multiply requesters and mult_arbiter.
// The master side drives requests and operands; the slave side answers.
interface mult_arbiter_if;
    logic        iReq0;
    logic [15:0] iA0;
    logic [15:0] iB0;
    logic        iReq1;
    logic [15:0] iA1;
    logic [15:0] iB1;
    logic        oAck0;
    logic        oAck1;
    logic        oDone0;
    logic        oDone1;
    logic [31:0] oResult;
    logic        oBusy;

    modport master (
        output iReq0, iA0, iB0, iReq1, iA1, iB1,
        input  oAck0, oAck1, oDone0, oDone1, oResult, oBusy
    );

    modport slave (
        input  iReq0, iA0, iB0, iReq1, iA1, iB1,
        output oAck0, oAck1, oDone0, oDone1, oResult, oBusy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester arbiter sharing one 16x16 multiplier with a settle window.
// Define ARB_ROUND_ROBIN_EN for round-robin contention, else requester 0 wins.
module MULTIPLIER (
    input  logic [15:0] wA,
    input  logic [15:0] wB,
    output logic [31:0] oOUT
);
    assign oOUT = 32'(wA) * 32'(wB);
endmodule

module mult_arbiter #(
    parameter int MULT_STAGES = 1
) (
    input  logic           Clock,
    input  logic           Reset,
    mult_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(MULT_STAGES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        owner_q, owner_d;

    logic        any_req;
    logic        win;
    logic        ack0, ack1;
    logic        done0, done1;
    logic [31:0] prod;

    MULTIPLIER u_mult (
        .wA   (a_q),
        .wB   (b_q),
        .oOUT (prod)
    );

    assign any_req = bus.iReq0 | bus.iReq1;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q names the requester favoured on the next contention
    logic rr_q, rr_d;

    always_comb begin
        win  = bus.iReq1 & (~bus.iReq0 | rr_q);
        rr_d = rr_q;
        if (ack0 | ack1) begin
            rr_d = ~win;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        win = bus.iReq1 & ~bus.iReq0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        owner_d = owner_q;
        ack0    = 1'b0;
        ack1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && Reset) begin
                    ack0    = ~win;
                    ack1    = win;
                    a_d     = win ? bus.iA1 : bus.iA0;
                    b_d     = win ? bus.iB1 : bus.iB0;
                    owner_d = win;
                    cnt_d   = 3'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 3'd0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CAPTURE: begin
                res_d   = prod;
                state_d = DONE;
            end
            DONE: begin
                // Reset low in this cycle aborts the op, so no pulse
                done0   = Reset & ~owner_q;
                done1   = Reset & owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            res_q   <= 32'd0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            owner_q <= owner_d;
        end
    end

    assign bus.oAck0   = ack0;
    assign bus.oAck1   = ack1;
    assign bus.oDone0  = done0;
    assign bus.oDone1  = done1;
    assign bus.oResult = res_q;
    assign bus.oBusy   = Reset & ((state_q != IDLE) | ack0 | ack1);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: one instance at MULT_STAGES=1, one at 4,
// both fed from the same requester signals.
module tb_mult_arbiter;
    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    mult_arbiter_if if1 ();
    mult_arbiter_if if4 ();

    assign if4.iReq0 = if1.iReq0;
    assign if4.iA0   = if1.iA0;
    assign if4.iB0   = if1.iB0;
    assign if4.iReq1 = if1.iReq1;
    assign if4.iA1   = if1.iA1;
    assign if4.iB1   = if1.iB1;

    mult_arbiter #(.MULT_STAGES(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if1.slave)
    );

    mult_arbiter #(.MULT_STAGES(4)) dut4 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if4.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        bit          r;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic samp(input bit sel, output logic a0, output logic a1,
                        output logic d0, output logic d1, output logic bz,
                        output logic [31:0] res);
        if (sel) begin
            a0 = if4.oAck0; a1 = if4.oAck1;
            d0 = if4.oDone0; d1 = if4.oDone1;
            bz = if4.oBusy; res = if4.oResult;
        end else begin
            a0 = if1.oAck0; a1 = if1.oAck1;
            d0 = if1.oDone0; d1 = if1.oDone1;
            bz = if1.oBusy; res = if1.oResult;
        end
    endtask

    task automatic do_op(input bit sel, input bit r, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp,
                         input int lat, input string nm);
        logic a0, a1, d0, d1, bz;
        logic [31:0] res;
        int k;
        bit got;
        bit bbad;
        @(negedge Clock);
        if1.iReq0 = !r;
        if1.iReq1 = r;
        if (r) begin
            if1.iA1 = a; if1.iB1 = b;
        end else begin
            if1.iA0 = a; if1.iB0 = b;
        end
        #1;
        samp(sel, a0, a1, d0, d1, bz, res);
        chk({nm, "_ack"}, 32'(r ? {a1, a0} : {a0, a1}), 32'd2);
        chk({nm, "_busy_ack"}, 32'(bz), 32'd1);
        k = 0;
        got = 0;
        bbad = 0;
        while (!got && k < 20) begin
            @(negedge Clock);
            if (k == 0) begin
                if1.iReq0 = 1'b0;
                if1.iReq1 = 1'b0;
                // operand changes after ack must not reach the product
                if (r) if1.iA1 = a + 16'd4;
                else   if1.iA0 = a + 16'd4;
            end
            #1;
            samp(sel, a0, a1, d0, d1, bz, res);
            k++;
            if (!bz) bbad = 1;
            if (d0 | d1) begin
                got = 1;
                chk({nm, "_owner"}, 32'({d0, d1}), r ? 32'd1 : 32'd2);
            end
        end
        chk({nm, "_lat"}, 32'(k), 32'(lat));
        chk({nm, "_res"}, res, exp);
        chk({nm, "_busy_hold"}, 32'(bbad), 32'd0);
        @(negedge Clock);
        #1;
        samp(sel, a0, a1, d0, d1, bz, res);
        chk({nm, "_busy_end"}, 32'(bz), 32'd0);
    endtask

    vec_t vecs[7];
    int   exp_g[4];
    int   g[$];

    initial begin
        logic a0, a1, d0, d1, bz;
        logic [31:0] res;
        int nd;
        int cyc;
        int dual;
        bit seen;

        total = 0;
        bad = 0;
        vecs[0] = '{0, 16'd5, 16'd5, 32'd25, "v5x5"};
        vecs[1] = '{1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "vmax"};
        vecs[2] = '{1, 16'h1234, 16'h0000, 32'd0, "vzero_b"};
        vecs[3] = '{0, 16'h0000, 16'hFFFF, 32'd0, "vzero_a"};
        vecs[4] = '{0, 16'hFFFF, 16'h0001, 32'h0000FFFF, "vone"};
        vecs[5] = '{1, 16'h0100, 16'h0100, 32'h00010000, "vshift"};
        vecs[6] = '{0, 16'd1000, 16'd3, 32'd3000, "v1000"};
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        Reset = 1'b0;
        if1.iReq0 = 1'b0; if1.iA0 = '0; if1.iB0 = '0;
        if1.iReq1 = 1'b0; if1.iA1 = '0; if1.iB1 = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        #1;
        samp(0, a0, a1, d0, d1, bz, res);
        chk("rst_ack", 32'({a0, a1}), 32'd0);
        chk("rst_done", 32'({d0, d1}), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_res", res, 32'd0);

        // both requesters held continuously
        @(negedge Clock);
        if1.iReq0 = 1'b1; if1.iA0 = 16'd7;  if1.iB0 = 16'd3;
        if1.iReq1 = 1'b1; if1.iA1 = 16'd11; if1.iB1 = 16'd13;
        nd = 0;
        cyc = 0;
        dual = 0;
        while (nd < 4 && cyc < 60) begin
            #1;
            samp(0, a0, a1, d0, d1, bz, res);
            if (a0 && a1) dual++;
            if (d0 && d1) dual++;
            if (a0) g.push_back(0);
            if (a1) g.push_back(1);
            if (d0) begin
                nd++;
                chk("cont_res0", res, 32'd21);
            end
            if (d1) begin
                nd++;
                chk("cont_res1", res, 32'd143);
            end
            cyc++;
            @(negedge Clock);
        end
        if1.iReq0 = 1'b0;
        if1.iReq1 = 1'b0;
        chk("cont_dones", 32'(nd), 32'd4);
        chk("cont_dual", 32'(dual), 32'd0);
        // 4 grants over 4 ops at 4 cycles each
        chk("cont_cycles", 32'(cyc), 32'd16);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_grant%0d", i),
                32'(g.size() > i ? g[i] : 9), 32'(exp_g[i]));
        end

        repeat (8) @(negedge Clock);
        for (int i = 0; i < 7; i++) begin
            do_op(0, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, 3,
                  vecs[i].nm);
        end

        // reset during SETTLE aborts the op
        @(negedge Clock);
        if1.iReq0 = 1'b1; if1.iA0 = 16'd6; if1.iB0 = 16'd6;
        #1;
        chk("abort_ack", 32'(if1.oAck0), 32'd1);
        @(negedge Clock);
        if1.iReq0 = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (if1.oDone0 | if1.oDone1) seen = 1;
            @(negedge Clock);
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        chk("abort_res", if1.oResult, 32'd0);
        do_op(0, 0, 16'd2, 16'd3, 32'd6, 3, "post_rst");

        repeat (12) @(negedge Clock);
        do_op(1, 0, 16'd4, 16'd4, 32'd16, 6, "ms4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: MULT_STAGES, default 1, number of settle cycles the shared 16x16 MULTIPLIER product is given before capture (legal 1..7).
REQ-002 Clock  input  1  single rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-low reset, sampled on rising edge of Clock.
REQ-004 iReq0  input  1  requester 0 operation request (level).
REQ-005 iA0, iB0  input  16 each  requester 0 operands (unsigned).
REQ-006 iReq1  input  1  requester 1 operation request (level).
REQ-007 iA1, iB1  input  16 each  requester 1 operands (unsigned).
REQ-008 oAck0, oAck1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-009 oDone0, oDone1  output  1 each  one-cycle pulse: oResult valid for that requester.
REQ-010 oResult  output  32  product of the last completed operation, held until next capture.
REQ-011 oBusy  output  1  high from acceptance through the oDone cycle.
REQ-012 Block SHALL instantiate exactly one MULTIPLIER (wA, wB, oOUT) fed from internal operand registers.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-014 IDLE: when any iReq high, SHALL select a winner, latch its iA/iB into operand registers, pulse its oAck, go to SETTLE.
REQ-015 SETTLE: 3-bit counter SHALL count MULT_STAGES cycles, then go to CAPTURE.
REQ-016 CAPTURE: oResult SHALL register MULTIPLIER oOUT (full 32-bit, no truncation), go to DONE.
REQ-017 DONE: SHALL pulse oDone of the owner for exactly one cycle, return to IDLE.
REQ-018 Latency: oAck in cycle N -> oDone in cycle N+MULT_STAGES+2; oResult valid from that cycle on.
REQ-019 Only one oAck and one oDone SHALL be high in any cycle; oAck never coincides with oBusy already high from a prior op.
REQ-020 Requester SHALL hold iReq and operands stable until its oAck; iReq still high in the cycle after oDone is a new request.
REQ-021 Requests arriving while busy SHALL wait; no request is dropped or queued beyond the iReq level.
REQ-022 Operand changes after oAck SHALL NOT affect the in-flight product.
REQ-023 Arbitration on simultaneous iReq0 and iReq1 per REQ-028/REQ-029; single request always wins.
REQ-024 Edge values: 0xFFFF*0xFFFF SHALL yield 0xFFFE0001; any operand 0 yields 0.

Reset
REQ-025 Reset low SHALL force state IDLE, counter 0, operand registers 0, oResult 0, oAck*/oDone*/oBusy 0, round-robin pointer to requester 0.
REQ-026 Reset mid-operation SHALL abort it: no oDone issued for the aborted op, oResult cleared.
REQ-027 First acceptance possible in the first cycle after Reset returns high.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined: on contention, the requester not granted most recently wins; pointer updates on each oAck.
REQ-029 Without ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins contention; no pointer register exists.

Verification
REQ-030 MULT_STAGES=1, iReq0 with 5,5 -> oAck0 at N, oDone0 at N+3, oResult=25, oBusy high N..N+3.
REQ-031 iReq1 with 0xFFFF,0xFFFF -> oDone1 with oResult=0xFFFE0001; 0x1234*0 -> 0.
REQ-032 Both requests held continuously (7*3 on 0, 11*13 on 1): RR build grants 0,1,0,1 with results 21,143 alternating; non-RR build grants 0 only, requester 1 starved.
REQ-033 Change iA0 from 5 to 9 the cycle after oAck0 (iB0=5) -> oResult=25, not 45.
REQ-034 Assert Reset low in SETTLE of an op 6*6 -> no oDone, oResult=0, next op 2*3 completes with 6 at nominal latency.
REQ-035 MULT_STAGES=4, iReq0 4,4 -> oDone0 exactly 6 cycles after oAck0, oResult=16.
